// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command type, sequencer states and bus widths
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] wdata;
  } i2c_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous command FIFO (push/pop with full/empty, head shown on data_o)
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  logic     pop_i,
  input  i2c_cmd_t data_i,
  output i2c_cmd_t data_o,
  output logic     full_o,
  output logic     empty_o
);
  i2c_cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C commands, issues them to the master over enable/ready, returns one response each
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ISSUE_TIMEOUT = 16,
  parameter int TXN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic                  cmd_rw,
  input  logic [I2C_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [I2C_ADDR_W-1:0] rsp_addr,
  output logic                  rsp_rw,
  output logic [I2C_DATA_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [I2C_ADDR_W-1:0] address,
  output logic [I2C_DATA_W-1:0] data_in,
  output logic                  rw,
  output logic                  enable,
  input  logic [I2C_DATA_W-1:0] data_out,
  input  logic                  ready,
  output logic                  busy
);
  localparam int CW = $clog2(TXN_TIMEOUT + 1);
  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  i2c_cmd_t cur_q, cur_d, head, cmd_in;
  logic enable_q, enable_d, rsp_valid_q, rsp_valid_d, rsp_rw_q, rsp_rw_d, rsp_err_q, rsp_err_d;
  logic [I2C_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [I2C_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic full, empty, pop, done, err;
  assign cmd_in = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(cmd_valid), .pop_i(pop), .data_i(cmd_in),
    .data_o(head), .full_o(full), .empty_o(empty)
  );
  assign cmd_ready = !full;
  assign busy = state_q != IDLE || !empty;
  assign {address, rw, data_in} = cur_q;
  assign enable = enable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_rw = rsp_rw_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    enable_d = enable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d = rsp_addr_q;
    rsp_rw_d = rsp_rw_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    pop = 1'b0;
    done = 1'b0;
    err = 1'b0;
    case (state_q)
      IDLE: if (!empty && ready) begin
        pop = 1'b1;
        cur_d = head;
        enable_d = 1'b1;
        cnt_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (!ready) begin
        enable_d = 1'b0;
        cnt_d = '0;
        state_d = WAIT;
      end else if (cnt_q == CW'(ISSUE_TIMEOUT - 1)) begin
        done = 1'b1;
        err = 1'b1;
      end else cnt_d = cnt_inc;
      WAIT: if (ready) done = 1'b1;
      else if (cnt_q == CW'(TXN_TIMEOUT - 1)) begin
        done = 1'b1;
        err = 1'b1;
      end else cnt_d = cnt_inc;
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (done) begin
      state_d = RESP;
      enable_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_addr_d = cur_q.addr;
      rsp_rw_d = cur_q.rw;
      rsp_err_d = err;
      rsp_data_d = (!err && cur_q.rw) ? data_out : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_q <= '0;
      enable_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q <= '0;
      rsp_rw_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      enable_q <= enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_rw_q <= rsp_rw_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: scoreboard bench with a behavioural master stub and three slave addresses
module tb_i2c_cmd_sequencer;
  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b1;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_rw, rsp_err, rw, enable, ready, busy;
  logic [6:0] rsp_addr, address;
  logic [7:0] rsp_data, data_in, data_out;
  exp_t got, e;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [1:0] mode = 2'd0;
  logic force_low = 1'b0, ready_q, s_busy, s_rw;
  logic [6:0] s_addr;
  logic [7:0] s_wd;
  logic [7:0] slave_mem [128];
  int lat_cnt, en_run;
  int en_pulses = 0, en_len = 0;
  bit ok;
  i2c_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .address(address), .data_in(data_in), .rw(rw), .enable(enable), .data_out(data_out),
    .ready(ready), .busy(busy)
  );
  always #5 clk = ~clk;
  assign got = {rsp_addr, rsp_rw, rsp_data, rsp_err};
  assign ready = ready_q && !force_low;
  function automatic logic [7:0] rd_of(input logic [6:0] a);
    return a == 7'h2A ? 8'hF0 : a == 7'h33 ? 8'h5C : a == 7'h1D ? 8'h81 : 8'hEE;
  endfunction
  // mode 0: normal master, 1: never drops ready, 2: drops ready and never returns
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      s_busy <= 1'b0;
      data_out <= '0;
      lat_cnt <= 0;
    end else if (!s_busy) begin
      if (enable && ready && mode != 2'd1) begin
        ready_q <= 1'b0;
        s_busy <= 1'b1;
        s_addr <= address;
        s_rw <= rw;
        s_wd <= data_in;
        lat_cnt <= 5;
        if (mode == 2'd2) data_out <= 8'hAB;
      end
    end else if (mode == 2'd0) begin
      if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
      else begin
        ready_q <= 1'b1;
        s_busy <= 1'b0;
        data_out <= s_rw ? rd_of(s_addr) : 8'h00;
        if (!s_rw) slave_mem[s_addr] <= s_wd;
      end
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) en_run <= 0;
    else if (enable) en_run <= en_run + 1;
    else if (en_run != 0) begin
      en_len <= en_run;
      en_pulses <= en_pulses + 1;
      en_run <= 0;
    end
  end
  task automatic push_cmd(input logic [6:0] a, input logic r, input logic [7:0] w,
                          input logic [7:0] xd, input logic xe);
    int n = 0;
    cmd_addr = a; cmd_rw = r; cmd_wdata = w; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin n++; @(negedge clk); end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout addr=%h cmd_ready stuck at 0, required 1", a);
    end else sb.push_back('{addr: a, rw: r, data: xd, err: xe});
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; break; end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({rsp_valid, rsp_addr, rsp_rw, rsp_data, rsp_err, address, data_in, rw, enable, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {rsp_valid, rsp_addr, rsp_rw, rsp_data, rsp_err, address, data_in, rw, enable, busy});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_single_write;
    int p0 = en_pulses;
    cmd_addr = 7'h2A; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    sb.push_back('{addr: 7'h2A, rw: 1'b0, data: 8'h00, err: 1'b0});
    @(posedge clk); #1 cmd_valid = 1'b0;
    checks++;
    if (enable !== 1'b0) begin errors++; $display("FAIL latency_push_edge enable=%b required 0", enable); end
    @(posedge clk); #1;
    checks++;
    if (enable !== 1'b1) begin errors++; $display("FAIL latency_pop_edge enable=%b required 1", enable); end
    wait_rsp(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL single_rsp got %h required %h valid=%b", got, e, ok); end
    @(posedge clk); #1;
    checks++;
    if (en_pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses got %0d required 1", en_pulses - p0); end
    checks++;
    if (slave_mem[7'h2A] !== 8'hA5) begin errors++; $display("FAIL single_slave0 got %h required a5", slave_mem[7'h2A]); end
  endtask
  task automatic test_batch_full;
    force_low = 1'b1;
    push_cmd(7'h2A, 1'b0, 8'hA5, 8'h00, 1'b0);
    push_cmd(7'h33, 1'b0, 8'h3C, 8'h00, 1'b0);
    push_cmd(7'h1D, 1'b0, 8'h77, 8'h00, 1'b0);
    push_cmd(7'h2A, 1'b1, 8'h00, 8'hF0, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || enable !== 1'b0) begin
      errors++;
      $display("FAIL batch_full cmd_ready=%b busy=%b enable=%b required 0/1/0", cmd_ready, busy, enable);
    end
    force_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin errors++; $display("FAIL batch_rsp%0d got %h required %h valid=%b", i, got, e, ok); end
      @(posedge clk); #1;
    end
    checks++;
    if ({slave_mem[7'h33], slave_mem[7'h1D]} !== 16'h3C77) begin
      errors++;
      $display("FAIL batch_slaves got %h%h required 3c77", slave_mem[7'h33], slave_mem[7'h1D]);
    end
  endtask
  task automatic test_backpressure;
    int p0;
    rsp_ready = 1'b0;
    push_cmd(7'h33, 1'b0, 8'h11, 8'h00, 1'b0);
    push_cmd(7'h1D, 1'b1, 8'h00, 8'h81, 1'b0);
    wait_rsp(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL bp_first got %h required %h valid=%b", got, e, ok); end
    p0 = en_pulses;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || got !== e || enable !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got %h valid=%b enable=%b required %h/1/0", i, got, rsp_valid, enable, e);
      end
    end
    checks++;
    if (en_pulses != p0) begin errors++; $display("FAIL bp_no_issue pulses got %0d required %0d", en_pulses, p0); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    wait_rsp(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL bp_second got %h required %h valid=%b", got, e, ok); end
    @(posedge clk); #1;
  endtask
  task automatic test_issue_timeout;
    mode = 2'd1;
    push_cmd(7'h2A, 1'b1, 8'h00, 8'h00, 1'b1);
    push_cmd(7'h33, 1'b0, 8'h44, 8'h00, 1'b0);
    wait_rsp(ok);
    mode = 2'd0;
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL issue_to_rsp got %h required %h valid=%b", got, e, ok); end
    @(posedge clk); #1;
    checks++;
    if (en_len !== 16) begin errors++; $display("FAIL issue_to_len enable high %0d clocks, required 16", en_len); end
    wait_rsp(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL issue_to_next got %h required %h valid=%b", got, e, ok); end
    @(posedge clk); #1;
    checks++;
    if (slave_mem[7'h33] !== 8'h44) begin errors++; $display("FAIL issue_to_slave got %h required 44", slave_mem[7'h33]); end
  endtask
  task automatic test_reset_mid_wait;
    int n = 0;
    mode = 2'd2;
    push_cmd(7'h1D, 1'b0, 8'h55, 8'h00, 1'b0);
    push_cmd(7'h33, 1'b1, 8'h00, 8'h5C, 1'b0);
    while (enable !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    while (enable !== 1'b0 && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL rstw_reach_wait enable pulse not seen within %0d clocks", n); end
    repeat (10) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++;
    if ({enable, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rstw_async en/rv/busy/crdy got %b required 0001", {enable, rsp_valid, busy, cmd_ready});
    end
    sb.delete();
    mode = 2'd0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({enable, rsp_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstw_after cycle %0d en/rv/busy got %b required 000", i, {enable, rsp_valid, busy});
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_txn_timeout;
    int n = 0;
    mode = 2'd2;
    push_cmd(7'h33, 1'b1, 8'h00, 8'h00, 1'b1);
    while (enable !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    while (enable !== 1'b0 && n < 200) begin n++; @(negedge clk); end
    n = 0;
    while (!rsp_valid && n < 3000) begin n++; @(negedge clk); end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL txn_to_len WAIT lasted %0d clocks, required 1024", n); end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL txn_to_rsp got %h required %h", got, e); end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_batch_full();
    test_backpressure();
    test_issue_timeout();
    test_reset_mid_wait();
    test_txn_timeout();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover %0d responses outstanding, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command front-end sitting directly upstream of `i2c_master_controller`. It queues I2C transactions (address, direction, write byte) from a valid/ready command port, issues them one at a time on the master's `enable`/`ready` handshake, and returns one response per command: the read byte, or an error flag on timeout. It lets the system queue a batch of multi-slave writes and reads without babysitting the master's `ready` line.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `ISSUE_TIMEOUT`, 16: maximum clocks `enable` is held waiting for the master to drop `ready`.
- `TXN_TIMEOUT`, 1024: maximum clocks waiting for `ready` to return after acceptance.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full.
- `cmd_addr` in 7: 7-bit slave address.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `cmd_wdata` in 8: write byte; ignored for reads.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed.
- `rsp_addr` out 7: address of the completed command.
- `rsp_rw` out 1: direction of the completed command.
- `rsp_data` out 8: `data_out` captured for reads; 0 for writes and errors.
- `rsp_err` out 1: transaction timed out.
- `address` out 7: to the master.
- `data_in` out 8: to the master.
- `rw` out 1: to the master.
- `enable` out 1: to the master.
- `data_out` in 8: from the master.
- `ready` in 1: from the master; high means idle.
- `busy` out 1: the FSM is not in IDLE, or the FIFO is not empty.

## Operation
- A push occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full`, evaluated combinationally from the FIFO count.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is not empty and `ready`=1, pop the head, register it into `address`/`rw`/`data_in`, set `enable`=1, and go to ISSUE.
- **ISSUE:** hold `enable`=1.
  - If `ready`=0 is sampled, drop `enable` and go to WAIT, clearing the counter.
  - After `ISSUE_TIMEOUT` clocks without `ready` falling, drop `enable`, set err, and go to RESP.
- **WAIT:** `enable`=0.
  - When `ready` returns to 1, capture `data_out` into `rsp_data` if `rw`=1, otherwise load 0. Go to RESP with err=0.
  - After `TXN_TIMEOUT` clocks, set err, `rsp_data`=0, and go to RESP.
- **RESP:** `rsp_valid`=1. On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- Response fields are stable while `rsp_valid`=1.
- `address`, `rw` and `data_in` are held stable from the pop until the next pop.
- A push and a pop in the same cycle on a full FIFO: the push is refused, because `cmd_ready` is 0 that cycle.
- A push and a pop in the same cycle on a non-full, non-empty FIFO: both happen and the count is unchanged.
- Commands complete strictly in FIFO order. A timed-out command is dropped and not retried; the FIFO continues with the next command.

## Timing
- Every output resets to 0, except `cmd_ready`=1. The FIFO pointers and count reset to 0.
- Latency, with an idle master and an empty FIFO:
  - Command pushed at edge N.
  - Pop and `enable`=1 after edge N+1.
  - Response visible in the cycle after `ready` rises.
- `enable` is high for at least 1 and at most `ISSUE_TIMEOUT` clocks.
- Back-to-back commands: the next pop happens at the edge after `rsp_ready` is accepted, provided `ready`=1.
- Counter width is `$clog2(TXN_TIMEOUT+1)`. It saturates and never wraps.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. The count is one bit wider, so full and empty are distinct.
- Reset mid-transaction: all state clears asynchronously, queued commands are lost, and `enable` deasserts immediately.

## Structure
- Package `i2c_pkg` holds:
  - `i2c_cmd_t` (`addr`[6:0], `rw`, `wdata`[7:0]);
  - `seq_state_e` (IDLE, ISSUE, WAIT, RESP);
  - `I2C_ADDR_W`=7 and `I2C_DATA_W`=8.
- The sub-module `i2c_cmd_fifo` is a synchronous FIFO parameterized on `DEPTH` with a width of `$bits(i2c_cmd_t)`. It has push/pop ports and full/empty outputs.
- The sequencer instantiates one `i2c_cmd_fifo` and holds the FSM, the timeout counter and the response register.

## Test plan
- **Single write:** push {0x2A, w, 0xA5} with the real master and three slaves attached. Required: one `enable` pulse, then a response with `rsp_addr`=0x2A, `rsp_rw`=0, `rsp_err`=0, `rsp_data`=0, and slave0 has received 0xA5.
- **Batch with a full FIFO:** push writes to 0x2A/0x33/0x1D (0xA5/0x3C/0x77) plus a read of 0x2A, with slave0 sending 0xF0 and `DEPTH`=4.
  - `cmd_ready` drops after the fourth push while the first command is still unpopped.
  - Four responses arrive in order; the last has `rsp_data`=0xF0.
- **Response backpressure:** hold `rsp_ready`=0 for 50 clocks after the first response. Required: the response fields stay stable, no second `enable` is issued, and completion resumes on release.
- **Issue timeout:** use a master stub that holds `ready`=1 and never drops it. Required: `enable` stays high for exactly 16 clocks, then `rsp_err`=1, and the next command is issued.
- **Transaction timeout:** use a stub that drops `ready` and never raises it. Required: `rsp_err`=1 after 1024 clocks in WAIT, with `rsp_data`=0.
- **Reset mid-WAIT:** assert `rst` asynchronously between clock edges. Required: `enable`, `rsp_valid` and `busy` are 0 immediately, `cmd_ready`=1, and the FIFO is empty with no stale response after release.
